// File: rtl/switch_debouncer.sv
// Per-channel switch debouncer: two-flop synchronizer, saturating stability
// counter, and registered level / toggle-pulse / rising-pulse outputs.
module switch_debouncer #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_changed,
    output logic [WIDTH-1:0] sw_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            deb_q, deb_d;
    logic [WIDTH-1:0]            chg_q, chg_d;
    logic [WIDTH-1:0]            rise_q, rise_d;

    // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching edges.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        chg_d   = '0;
        rise_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]  = '0;
                deb_d[i]  = sync2_q[i];
                chg_d[i]  = 1'b1;
                rise_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
            chg_q   <= '0;
            rise_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            chg_q   <= chg_d;
            rise_q  <= rise_d;
        end
    end

    assign sw_debounced = deb_q;
    assign sw_changed   = chg_q;
    assign sw_rise      = rise_q;

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning number of independent switch channels.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive clk edges a new level must persist before acceptance (1 ms at 50 MHz); legal range 2 to 2^20.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port sw_raw, input, WIDTH bits: raw, asynchronous, bouncing switch levels from board pins.
REQ-006 SHALL provide port sw_debounced, output, WIDTH bits, registered: clean switch levels driven directly into the downstream PIO in_port.
REQ-007 SHALL provide port sw_changed, output, WIDTH bits, registered: one-cycle pulse per bit when that bit of sw_debounced toggles.
REQ-008 SHALL provide port sw_rise, output, WIDTH bits, registered: one-cycle pulse per bit when that bit of sw_debounced goes 0->1.

Function
REQ-009 SHALL pass each sw_raw bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 SHALL keep one counter per bit, width ceil(log2(DEBOUNCE_CYCLES)), with no counter shared between bits.
REQ-011 SHALL, per bit on each edge where sync2 == sw_debounced, load counter with 0.
REQ-012 SHALL, per bit on each edge where sync2 != sw_debounced and counter < DEBOUNCE_CYCLES-1, increment the counter by 1.
REQ-013 SHALL, per bit on the edge where sync2 != sw_debounced and counter == DEBOUNCE_CYCLES-1, load sw_debounced with sync2 and load the counter with 0.
REQ-014 SHALL assert sw_changed for exactly the one cycle following the REQ-013 update.
REQ-015 SHALL assert sw_rise in that same cycle only when the new value is 1; sw_changed and sw_rise SHALL be 0 in all other cycles.
REQ-016 SHALL give a latency of exactly DEBOUNCE_CYCLES+2 rising edges from the first edge that samples a stable new sw_raw level to the edge that updates sw_debounced.
REQ-017 SHALL, when the mismatch disappears at any count (bounce shorter than DEBOUNCE_CYCLES edges), clear the counter and leave sw_debounced and the pulse outputs unchanged.
REQ-018 SHALL keep the counter from wrapping: the terminal count always resolves via REQ-013 and never rolls over to 0 by increment.
REQ-019 SHALL process bits independently, so that simultaneous transitions on several bits yield simultaneous pulses on the corresponding output bits.
REQ-020 SHALL never assert sw_changed on consecutive cycles for the same bit, because a reversal needs at least DEBOUNCE_CYCLES further edges.

Reset
REQ-021 SHALL, while reset is 1 and independent of clk, clear sync1, sync2, all counters, sw_debounced, sw_changed and sw_rise to 0.
REQ-022 SHALL discard any in-progress count when reset is asserted mid-count; after release, debounce restarts from 0 against sw_debounced = 0.
REQ-023 SHALL, when sw_raw bit is held 1 through reset release, set that sw_debounced bit to 1 after DEBOUNCE_CYCLES+2 edges and pulse sw_changed and sw_rise once.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-024 SHALL cover reset: assert reset mid-cycle with sw_raw=8'hFF -> all outputs read 0 immediately, with no clk edge needed.
REQ-025 SHALL cover the clean edge: sw_raw 8'h00->8'h01 held -> sw_debounced=8'h01 exactly 6 edges later; sw_changed=8'h01 and sw_rise=8'h01 for one cycle.
REQ-026 SHALL cover bounce rejection: bit 0 toggles high for 3 cycles, low for 1, high for 3, then returns low -> sw_debounced stays 8'h00 and no pulses occur.
REQ-027 SHALL cover the falling edge: from sw_debounced=8'h01, sw_raw->8'h00 held -> after 6 edges sw_debounced=8'h00, sw_changed=8'h01, sw_rise=8'h00.
REQ-028 SHALL cover simultaneous bits: sw_raw 8'h00->8'hA5 in one cycle -> sw_debounced=8'hA5 after 6 edges; sw_changed and sw_rise both 8'hA5 in the same single cycle.
REQ-029 SHALL cover reset mid-count: sw_raw=8'h01 for 3 edges, pulse reset, keep sw_raw=8'h01 -> sw_debounced=8'h01 exactly 6 edges after reset release.
